// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC reader: FSM state encoding and
// parameter defaults used by spi_adc_reader and its sub-modules.
package spi_adc_pkg;

  localparam int CHANNELS_DEF   = 1;
  localparam int FRAME_BITS_DEF = 16;
  localparam int DATA_FIRST_DEF = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int CLK_DIV_DEF    = 32;
  localparam int GAP_HALF_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator. A half-period counter runs at clk rate while
// 'run' is high; 'tick' marks the last cycle of each half-period. When
// 'toggle_en' is set the tick flips sck, and rise/fall announce which way
// sck changes at the end of the current cycle. sck is a plain register.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic toggle_en,
  output logic sck,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && toggle_en && !sck;
  assign fall = tick && toggle_en && sck;

  // Half-period counter and sck register; both park at zero when idle.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (rise)      sck <= 1'b1;
      else if (fall) sck <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_adc_reader.sv
// SPI ADC reader: drives cs_n/sck to one or more ADCs sharing the bus,
// captures a window of each frame from every sdo line and hands the words
// to a valid/ready consumer.
// Build option: define SPI_ADC_OVERRUN_EN to drop a frame that completes
// while the previous one is still unconsumed and raise a sticky overrun.
// Without it the new frame overwrites the held one and overrun is 0.
// Frame timeline (D = CLK_DIV): SETUP D cycles, FRAME_BITS sck periods,
// and the final sck low half-period is the HOLD window before cs_n rises.
module spi_adc_reader
  import spi_adc_pkg::*;
#(
  parameter int CHANNELS   = CHANNELS_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int DATA_FIRST = DATA_FIRST_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int GAP_HALF   = GAP_HALF_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  input  logic [CHANNELS-1:0]            sdo,
  output logic                           cs_n,
  output logic                           sck,
  output logic [CHANNELS*DATA_WIDTH-1:0] data,
  output logic                           valid,
  input  logic                           ready,
  output logic                           busy,
  output logic                           overrun
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = (GAP_HALF > 1) ? $clog2(GAP_HALF) : 1;

`ifdef SPI_ADC_OVERRUN_EN
  localparam bit KEEP_OLD = 1'b1;
`else
  localparam bit KEEP_OLD = 1'b0;
`endif

  spi_state_e                          state;
  logic [BW-1:0]                       bit_cnt;
  logic [GW-1:0]                       gap_cnt;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] shreg;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] data_q;
  logic tick, rise, fall;
  logic run, toggle_en, in_window, frame_done, blocked;

  assign run        = (state != ST_IDLE);
  assign toggle_en  = (state == ST_SETUP) || (state == ST_SHIFT);
  assign in_window  = (bit_cnt >= BW'(DATA_FIRST)) &&
                      (bit_cnt <  BW'(DATA_FIRST + DATA_WIDTH));
  assign frame_done = (state == ST_HOLD) && tick;
  assign blocked    = valid && !ready;
  assign busy       = run;
  assign data       = data_q;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .toggle_en(toggle_en),
    .sck      (sck),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall)
  );

  // Frame sequencing, chip select and per-channel bit capture on sck rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cs_n    <= 1'b1;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (rise) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (in_window)
          for (int k = 0; k < CHANNELS; k++)
            shreg[k] <= (shreg[k] << 1) | DATA_WIDTH'(sdo[k]);
      end
      case (state)
        ST_IDLE: begin
          // GAP always returns here, so continuous mode re-launches from
          // IDLE one cycle later, giving the extra cycle of cs_n high.
          if (start || continuous) begin
            state   <= ST_SETUP;
            cs_n    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_SETUP: if (tick) state <= ST_SHIFT;
        ST_SHIFT: if (fall && bit_cnt == BW'(FRAME_BITS)) state <= ST_HOLD;
        ST_HOLD: begin
          if (tick) begin
            state   <= ST_GAP;
            cs_n    <= 1'b1;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt == GW'(GAP_HALF - 1)) state <= ST_IDLE;
            else                               gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output word and valid handshake; a completing frame wins over a
  // simultaneous consume, so valid stays up with the fresh data.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      valid  <= 1'b0;
    end else if (frame_done) begin
      if (!(blocked && KEEP_OLD)) begin
        data_q <= shreg;
        valid  <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

`ifdef SPI_ADC_OVERRUN_EN
  // Sticky overrun: a frame finished while the consumer was stalled.
  always_ff @(posedge clk) begin
    if (reset)                     overrun <= 1'b0;
    else if (frame_done && blocked) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_reader.sv
// Directed/randomized bench for spi_adc_reader with two channels and a
// behavioural ADC that shifts a 16-bit word MSB-first, changing on sck fall.
module tb_spi_adc_reader;

  localparam int CH = 2;
  localparam int FB = 16;
  localparam int DF = 3;
  localparam int DW = 8;
  localparam int CD = 2;
  localparam int GH = 4;

  logic          clk = 1'b0;
  logic          reset, start, continuous, ready;
  logic [CH-1:0] sdo;
  logic          cs_n, sck, valid, busy, overrun;
  logic [CH*DW-1:0] data;

  int tests = 0;
  int fails = 0;

  logic [FB-1:0] next_word [CH];
  logic [FB-1:0] cur_word  [CH];
  int rises;
  int bi;

  spi_adc_reader #(
    .CHANNELS(CH), .FRAME_BITS(FB), .DATA_FIRST(DF),
    .DATA_WIDTH(DW), .CLK_DIV(CD), .GAP_HALF(GH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .sdo(sdo), .cs_n(cs_n), .sck(sck), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Behavioural ADC: latch the word at cs_n fall, present bit 0, move to
  // the next bit on every sck fall, count sck rises within the frame.
  initial begin
    sdo = '0;
    rises = 0;
    forever begin
      @(negedge cs_n);
      cur_word = next_word;
      rises = 0;
      bi = 0;
      for (int k = 0; k < CH; k++) sdo[k] = cur_word[k][FB-1];
      forever begin
        @(posedge sck or negedge sck or posedge cs_n);
        if (cs_n) break;
        if (sck) rises++;
        else begin
          bi++;
          if (bi < FB)
            for (int k = 0; k < CH; k++) sdo[k] = cur_word[k][FB-1-bi];
        end
      end
    end
  end

  // Reference: frame bit i is word bit FB-1-i; keep bits DF..DF+DW-1.
  function automatic logic [DW-1:0] ref_word(input logic [FB-1:0] w);
    return DW'(w >> (FB - DF - DW));
  endfunction

  function automatic logic [CH*DW-1:0] ref_data(input logic [FB-1:0] w0,
                                                input logic [FB-1:0] w1);
    return {ref_word(w1), ref_word(w0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int n = 0;
    while (cs_n !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, cs_n}, {31'b0, lvl});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check(tag, {31'b0, valid}, 32'd0);
  endtask

  // One single-shot frame; optionally re-pulse start mid-SHIFT and raise
  // ready exactly in the completion cycle.
  task automatic single_frame(input logic [FB-1:0] w0, input logic [FB-1:0] w1,
                              input bit rdy_done, input bit poke, input string tag);
    logic [CH*DW-1:0] exp = ref_data(w0, w1);
    next_word[0] = w0;
    next_word[1] = w1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;               // cycle t+1
    check({tag, "_csn_fall"}, {31'b0, cs_n}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    repeat (20) @(negedge clk);                // t+21
    if (poke) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);                            // t+23
    repeat (43) @(negedge clk);                // t+66
    check({tag, "_csn_t66"}, {31'b0, cs_n}, 32'd0);
    if (rdy_done) ready = 1'b1;
    @(negedge clk);                            // t+67
    ready = 1'b0;
    check({tag, "_csn_t67"}, {31'b0, cs_n}, 32'd1);
    check({tag, "_valid"}, {31'b0, valid}, 32'd1);
    check({tag, "_data"}, 32'(data), 32'(exp));
    check({tag, "_sck_pulses"}, 32'(rises), FB);
    check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
  endtask

  initial begin
    logic [FB-1:0] a0, a1, b0, b1;
    int n;

    reset = 1'b1; start = 1'b0; continuous = 1'b0; ready = 1'b0;
    next_word[0] = '0; next_word[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_csn",     {31'b0, cs_n},    32'd1);
    check("rst_sck",     {31'b0, sck},     32'd0);
    check("rst_data",    32'(data),        32'd0);
    check("rst_valid",   {31'b0, valid},   32'd0);
    check("rst_busy",    {31'b0, busy},    32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single shot with the reference pattern.
    b1 = 16'($urandom);
    single_frame(16'h14A0, b1, 1'b0, 1'b0, "single");
    check("single_ch0_a5", 32'(data[DW-1:0]), 32'h0000_00A5);
    check("single_in_gap", {31'b0, busy}, 32'd1);
    consume("single_consume");
    wait_idle("single_idle");

    // Continuous: two channels, gap timing, deassert during frame 2.
    next_word[0] = 16'h14A0;
    next_word[1] = 16'h0FE0;
    @(negedge clk) continuous = 1'b1;
    wait_cs(1'b0, "cont_fall1");
    wait_cs(1'b1, "cont_rise1");
    check("cont_data1",  32'(data),      32'h0000_7FA5);
    check("cont_valid1", {31'b0, valid}, 32'd1);
    a0 = 16'($urandom); a1 = 16'($urandom);
    next_word[0] = a0; next_word[1] = a1;
    n = 0;
    while (cs_n === 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("cont_gap_cycles", 32'(n), 32'd9);
    consume("cont_consume1");
    continuous = 1'b0;
    wait_cs(1'b1, "cont_rise2");
    check("cont_data2",  32'(data),      32'(ref_data(a0, a1)));
    check("cont_valid2", {31'b0, valid}, 32'd1);
    wait_idle("cont_idle");
    repeat (10) @(negedge clk);
    check("cont_stopped", {31'b0, cs_n}, 32'd1);

    // Start re-pulsed mid-SHIFT, consume coincides with completion.
    a0 = 16'($urandom); a1 = 16'($urandom);
    single_frame(a0, a1, 1'b1, 1'b1, "busy_start");
    wait_idle("busy_start_idle");
    repeat (10) @(negedge clk);
    check("busy_start_ignored", {31'b0, busy}, 32'd0);
    check("busy_start_valid", {31'b0, valid}, 32'd1);
    consume("busy_start_consume");

    // Two continuous frames with the consumer stalled.
    a0 = 16'($urandom); a1 = 16'($urandom);
    b0 = 16'($urandom); b1 = 16'($urandom);
    next_word[0] = a0; next_word[1] = a1;
    @(negedge clk) continuous = 1'b1;
    wait_cs(1'b0, "ovr_fall1");
    wait_cs(1'b1, "ovr_rise1");
    check("ovr_data1", 32'(data), 32'(ref_data(a0, a1)));
    next_word[0] = b0; next_word[1] = b1;
    wait_cs(1'b0, "ovr_fall2");
    continuous = 1'b0;
    wait_cs(1'b1, "ovr_rise2");
    check("ovr_valid", {31'b0, valid}, 32'd1);
`ifdef SPI_ADC_OVERRUN_EN
    check("ovr_data2",   32'(data),        32'(ref_data(a0, a1)));
    check("ovr_flag",    {31'b0, overrun}, 32'd1);
`else
    check("ovr_data2",   32'(data),        32'(ref_data(b0, b1)));
    check("ovr_flag",    {31'b0, overrun}, 32'd0);
`endif
    wait_idle("ovr_idle");

    // Reset at the 7th sck rise aborts the frame.
    a0 = 16'($urandom); a1 = 16'($urandom);
    next_word[0] = a0; next_word[1] = a1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (rises < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst7_reached", 32'(rises), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    check("rst7_csn",     {31'b0, cs_n},    32'd1);
    check("rst7_sck",     {31'b0, sck},     32'd0);
    check("rst7_valid",   {31'b0, valid},   32'd0);
    check("rst7_data",    32'(data),        32'd0);
    check("rst7_overrun", {31'b0, overrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    a0 = 16'($urandom); a1 = 16'($urandom);
    single_frame(a0, a1, 1'b0, 1'b0, "after_rst");
    consume("after_rst_consume");
    wait_idle("after_rst_idle");

    // Randomized single shots.
    for (int i = 0; i < 4; i++) begin
      a0 = 16'($urandom); a1 = 16'($urandom);
      single_frame(a0, a1, 1'b0, 1'b0, "rand");
      consume("rand_consume");
      wait_idle("rand_idle");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
